// File: rtl/pe_ctrl_pkg.sv
// Shared types and defaults for the payload match-engine sequencer.
// Holds the FSM state encoding, the default flush depth and the result record.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAIN,
        REPORT
    } state_e;

    localparam int DRAIN_CYC_DEF = 3;
    localparam int NUM_ENG_DEF   = 16;
    localparam int CNT_W_DEF     = 16;

    // Result record at the default engine count and counter width.
    typedef struct packed {
        logic [NUM_ENG_DEF-1:0] match;
        logic                   any;
        logic [CNT_W_DEF-1:0]   len;
    } pe_result_t;

endpackage

// File: rtl/payload_engine_ctrl.sv
// Sequences one bank of payload match engines per packet: clear, scan bytes,
// flush the engine pipeline, then hold a snapshot of the sticky matches.
module payload_engine_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int NUM_ENG   = NUM_ENG_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [7:0]         eng_char,
    output logic               eng_dvalid,
    output logic               eng_en,
    output logic               eng_sod,
    input  logic [NUM_ENG-1:0] eng_match,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [NUM_ENG-1:0] res_match,
    output logic               res_any,
    output logic [CNT_W-1:0]   res_len
);

    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // Same layout as pe_result_t, sized by this instance's parameters.
    typedef struct packed {
        logic [NUM_ENG-1:0] match;
        logic               any;
        logic [CNT_W-1:0]   len;
    } res_t;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       char_q, char_d;
    logic             dvalid_q, dvalid_d;
    logic             en_q, en_d;
    logic             sod_q, sod_d;
    res_t             res_q, res_d;
    logic             accept;

    assign s_ready = (state_q == SCAN);
    assign accept  = s_ready && s_valid;

    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        char_d  = char_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE:  if (s_valid) state_d = CLEAR;
            CLEAR: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
            SCAN: if (accept) begin
                char_d = s_data;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                if (s_last) begin
                    drain_d = DRAIN_LOAD;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_d = drain_q - DW'(1);
                if (drain_q == DW'(1)) begin
                    res_d.match = eng_match;
                    res_d.any   = |eng_match;
                    res_d.len   = cnt_q;
                    state_d     = REPORT;
                end
            end
            REPORT: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Engine controls are derived from the next state so they line up with state_q.
        dvalid_d = accept;
        en_d     = accept || (state_d == DRAIN);
        // NOTE: eng_sod feeds the engines' async clear, so it must come straight from a flop.
        sod_d    = (state_d == CLEAR);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            drain_q  <= '0;
            cnt_q    <= '0;
            char_q   <= '0;
            dvalid_q <= 1'b0;
            en_q     <= 1'b0;
            sod_q    <= 1'b1;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            cnt_q    <= cnt_d;
            char_q   <= char_d;
            dvalid_q <= dvalid_d;
            en_q     <= en_d;
            sod_q    <= sod_d;
            res_q    <= res_d;
        end
    end

    assign eng_char   = char_q;
    assign eng_dvalid = dvalid_q;
    assign eng_en     = en_q;
    assign eng_sod    = sod_q;
    assign res_valid  = (state_q == REPORT);
    assign res_match  = res_q.match;
    assign res_any    = res_q.any;
    assign res_len    = res_q.len;

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// Directed bench for payload_engine_ctrl with a small engine model that
// sticks bit 0 high once the byte sequence "%5C" has been shifted in.
module tb_payload_engine_ctrl;

    localparam int NUM_ENG   = 16;
    localparam int CNT_W     = 4;
    localparam int DRAIN_CYC = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         s_data = 8'h00;
    logic               s_valid = 1'b0;
    logic               s_last = 1'b0;
    logic               s_ready;
    logic [7:0]         eng_char;
    logic               eng_dvalid;
    logic               eng_en;
    logic               eng_sod;
    logic [NUM_ENG-1:0] eng_match;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [NUM_ENG-1:0] res_match;
    logic               res_any;
    logic [CNT_W-1:0]   res_len;

    payload_engine_ctrl #(
        .NUM_ENG  (NUM_ENG),
        .DRAIN_CYC(DRAIN_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .eng_char  (eng_char),
        .eng_dvalid(eng_dvalid),
        .eng_en    (eng_en),
        .eng_sod   (eng_sod),
        .eng_match (eng_match),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_match (res_match),
        .res_any   (res_any),
        .res_len   (res_len)
    );

    always #5 clk = ~clk;

    // Engine model: 3-deep decoded-char history plus a sticky match flag.
    logic [7:0] h1, h2, h3;
    logic       m0;
    wire  [7:0] dec = eng_dvalid ? eng_char : 8'h00;

    always @(posedge clk or posedge eng_sod) begin
        if (eng_sod) begin
            h1 <= 8'h00; h2 <= 8'h00; h3 <= 8'h00; m0 <= 1'b0;
        end else if (eng_en) begin
            h1 <= dec; h2 <= h1; h3 <= h2;
            m0 <= m0 | ({h3, h2, h1} == {"%", "5", "C"});
        end
    end
    assign eng_match = {{(NUM_ENG-1){1'b0}}, m0};

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int n_sod, n_gap, en_err, lat;
    bit ok;

    task automatic send(input string s, input bit gappy, input int stop_after);
        int i = 0;
        int cyc = 0;
        bit acc;
        bit in_scan;
        n_sod = 0; n_gap = 0; en_err = 0; ok = 1'b1;
        while (i < s.len() && !(stop_after > 0 && i >= stop_after)) begin
            if (cyc > 300) begin ok = 1'b0; break; end
            s_valid = !(gappy && (cyc % 3 == 2));
            s_data  = s[i];
            s_last  = (i == s.len() - 1);
            @(negedge clk);
            in_scan = s_ready;
            acc = s_valid && s_ready;
            if (s_ready && !s_valid) n_gap++;
            if (eng_sod) n_sod++;
            @(posedge clk); #1;
            if (in_scan && (eng_en !== acc)) en_err++;
            if (acc) i++;
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_result();
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string name, input logic [NUM_ENG-1:0] em,
                                input logic ea, input logic [CNT_W-1:0] el);
        chk_cnt++;
        if (lat !== DRAIN_CYC) $display("FAIL %s latency: got %0d want %0d", name, lat, DRAIN_CYC);
        else pass_cnt++;
        chk_cnt++;
        if ({res_match, res_any, res_len} !== {em, ea, el})
            $display("FAIL %s result: got match=%h any=%b len=%0d want match=%h any=%b len=%0d",
                     name, res_match, res_any, res_len, em, ea, el);
        else pass_cnt++;
    endtask

    task automatic take_result(input string name, input int hold, input logic [NUM_ENG-1:0] em,
                               input logic ea, input logic [CNT_W-1:0] el);
        int err = 0;
        res_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            s_valid = 1'b1;
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || s_ready !== 1'b0 || {res_match, res_any, res_len} !== {em, ea, el})
                err++;
        end
        s_valid = 1'b0;
        if (hold > 0) begin
            chk_cnt++;
            if (err != 0) $display("FAIL %s hold stability: got %0d bad cycles want 0", name, err);
            else pass_cnt++;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk_cnt++;
        if (res_valid !== 1'b0) $display("FAIL %s release: got res_valid=%b want 0", name, res_valid);
        else pass_cnt++;
    endtask

    task automatic check_rst_vals(input string name);
        chk_cnt++;
        if ({eng_sod, s_ready, eng_en, eng_dvalid, res_valid, res_any, res_len, eng_char, res_match}
            !== {1'b1, 5'b0, 4'h0, 8'h00, 16'h0000})
            $display("FAIL %s: got sod=%b rdy=%b en=%b dv=%b rv=%b any=%b len=%0d char=%h match=%h want sod=1 rest 0",
                     name, eng_sod, s_ready, eng_en, eng_dvalid, res_valid, res_any, res_len, eng_char, res_match);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        int stray = 0;
        repeat (2) @(posedge clk);
        #1;
        check_rst_vals("reset_values");
        rst = 1'b0;
        @(posedge clk); #1;
        send("ABCDEFGH", 1'b0, 5);
        rst = 1'b1;
        #1;
        check_rst_vals("mid_scan_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b0) stray++;
        end
        chk_cnt++;
        if (stray != 0) $display("FAIL aborted_packet_result: got %0d res_valid cycles want 0", stray);
        else pass_cnt++;
        send("AB", 1'b0, 0);
        chk_cnt++;
        if (n_sod !== 1 || !ok) $display("FAIL post_reset_clear: got sod cycles %0d ok=%b want 1 ok=1", n_sod, ok);
        else pass_cnt++;
        wait_result();
        check_result("post_reset", 16'h0000, 1'b0, 4'd2);
        take_result("post_reset", 0, 16'h0000, 1'b0, 4'd2);
    endtask

    task automatic test_attack();
        send("/%2E%2E%5C/", 1'b0, 0);
        chk_cnt++;
        if (n_sod !== 1 || !ok || en_err != 0)
            $display("FAIL attack_scan: got sod=%0d ok=%b en_err=%0d want 1 1 0", n_sod, ok, en_err);
        else pass_cnt++;
        wait_result();
        check_result("attack", 16'h0001, 1'b1, 4'd11);
        take_result("attack", 0, 16'h0001, 1'b1, 4'd11);
    endtask

    task automatic test_gapped();
        send("/%2E%2E%5C/", 1'b1, 0);
        chk_cnt++;
        if (n_gap == 0 || en_err != 0 || !ok)
            $display("FAIL gapped_eng_en: got gaps=%0d en_err=%0d ok=%b want gaps>0 en_err=0", n_gap, en_err, ok);
        else pass_cnt++;
        wait_result();
        check_result("gapped", 16'h0001, 1'b1, 4'd11);
        take_result("gapped", 0, 16'h0001, 1'b1, 4'd11);
    endtask

    task automatic test_single_byte();
        send("A", 1'b0, 0);
        chk_cnt++;
        if (n_sod !== 1 || !ok) $display("FAIL single_sod_pulse: got %0d want 1", n_sod);
        else pass_cnt++;
        res_ready = 1'b1;
        wait_result();
        check_result("single", 16'h0000, 1'b0, 4'd1);
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk_cnt++;
        if (res_valid !== 1'b0) $display("FAIL single_report_len: got res_valid=%b after one cycle want 0", res_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        send("%5C", 1'b0, 0);
        wait_result();
        check_result("backpressure", 16'h0001, 1'b1, 4'd3);
        take_result("backpressure", 10, 16'h0001, 1'b1, 4'd3);
        send("B", 1'b0, 0);
        wait_result();
        check_result("after_backpressure", 16'h0000, 1'b0, 4'd1);
        take_result("after_backpressure", 0, 16'h0000, 1'b0, 4'd1);
    endtask

    task automatic test_saturation();
        string s = "";
        for (int k = 0; k < 17; k++) s = {s, "x"};
        s = {s, "%5C"};
        send(s, 1'b0, 0);
        wait_result();
        check_result("saturation", 16'h0001, 1'b1, 4'd15);
        take_result("saturation", 0, 16'h0001, 1'b1, 4'd15);
    endtask

    initial begin
        test_reset();
        test_attack();
        test_gapped();
        test_single_byte();
        test_back_pressure();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
